// File: rtl/word_packer_if.sv
// Word packer handshake bundle: upstream word channel plus FIFO write side.
interface word_packer_if #(
  parameter int WORD_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic                  in_valid_i;
  logic [WORD_WIDTH-1:0] in_data_i;
  logic                  in_last_i;
  logic                  in_ready_o;
  logic                  push_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  full_i;
  logic [15:0]           blk_cnt_o;

  modport master (
    output in_valid_i, in_data_i, in_last_i, full_i,
    input  in_ready_o, push_o, data_o, blk_cnt_o
  );

  modport slave (
    input  in_valid_i, in_data_i, in_last_i, full_i,
    output in_ready_o, push_o, data_o, blk_cnt_o
  );
endinterface

// File: rtl/word_packer.sv
// Packs WORDS upstream words (first word = MSW) into one FIFO block.
// Define PACKER_PAD_EN to close a short block on in_last_i with zero padding.
module word_packer #(
  parameter int WORD_WIDTH = 32,
  parameter int DATA_WIDTH = 128
) (
  input  logic        clk,
  input  logic        rst,
  word_packer_if.slave bus
);
  localparam int WORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int IW    = $clog2(WORDS);

  typedef enum logic {FILL, PUSH} state_t;

  state_t                state, state_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [DATA_WIDTH-1:0] blk, blk_nx;
  logic [15:0]           cnt;
  logic                  accept;
  logic                  last_word;
  logic                  pad;

`ifdef PACKER_PAD_EN
  assign pad = bus.in_last_i;
`else
  logic unused_last;
  assign unused_last = bus.in_last_i;
  assign pad = 1'b0;
`endif

  assign bus.in_ready_o = (state == FILL) && !rst;
  assign bus.push_o     = (state == PUSH) && !bus.full_i && !rst;
  assign bus.data_o     = blk;
  assign bus.blk_cnt_o  = cnt;

  assign accept    = bus.in_valid_i && bus.in_ready_o;
  assign last_word = (idx == IW'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      idx   <= '0;
      blk   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      blk   <= blk_nx;
      if (bus.push_o)
        cnt <= cnt + 16'd1;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    unique case (state)
      FILL: begin
        if (accept) begin
          idx_nx = idx + IW'(1);
          if (last_word || pad) begin
            state_nx = PUSH;
            idx_nx   = '0;
          end
        end
      end
      PUSH: begin
        if (!bus.full_i)
          state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  // Slots past the closing word are cleared only on a padded close.
  always_comb begin
    blk_nx = blk;
    for (int k = 0; k < WORDS; k++) begin
      if (accept && idx == IW'(k))
        blk_nx[DATA_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH] = bus.in_data_i;
      else if (accept && pad && IW'(k) > idx)
        blk_nx[DATA_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH] = '0;
    end
  end
endmodule

// File: tb/tb_word_packer.sv
// Self-checking bench for word_packer against a queue-based block model.
// Honours PACKER_PAD_EN the same way as the design.
module tb_word_packer;
  localparam int WW = 32;
  localparam int DW = 128;
  localparam int NW = DW / WW;
`ifdef PACKER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  word_packer_if #(.WORD_WIDTH(WW), .DATA_WIDTH(DW)) bus ();

  word_packer #(.WORD_WIDTH(WW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [WW-1:0] m_q[$];
  logic          m_pend;
  logic [DW-1:0] m_blk;
  logic [15:0]   m_cnt;

  function automatic logic [DW-1:0] pack(input logic [WW-1:0] w[$]);
    logic [DW-1:0] b = '0;
    for (int k = 0; k < w.size(); k++)
      b[DW-1-k*WW -: WW] = w[k];
    return b;
  endfunction

  function automatic logic exp_ready();
    return !rst && !m_pend;
  endfunction

  function automatic logic exp_push();
    return !rst && m_pend && !bus.full_i;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_q.delete();
      m_pend = 1'b0;
      m_cnt  = '0;
    end else if (m_pend) begin
      if (!bus.full_i) begin
        m_pend = 1'b0;
        m_cnt  = m_cnt + 16'd1;
      end
    end else if (bus.in_valid_i) begin
      m_q.push_back(bus.in_data_i);
      if (m_q.size() == NW || (PAD && bus.in_last_i)) begin
        m_blk  = pack(m_q);
        m_pend = 1'b1;
        m_q.delete();
      end
    end
  endtask

  task automatic drive(input logic v, input logic [WW-1:0] d,
                       input logic l, input logic f);
    bus.in_valid_i = v;
    bus.in_data_i  = d;
    bus.in_last_i  = l;
    bus.full_i     = f;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    #1;
    n_cmp++;
    if (bus.in_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: got %b want 0", bus.in_ready_o);
    end
    n_cmp++;
    if (bus.push_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_push: got %b want 0", bus.push_o);
    end
    n_cmp++;
    if (bus.data_o !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", bus.data_o);
    end
    n_cmp++;
    if (bus.blk_cnt_o !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_cnt: got %h want 0", bus.blk_cnt_o);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_ready: got %b want 1", bus.in_ready_o);
    end
  endtask

  task automatic test_basic();
    logic [WW-1:0] w[4];
    logic [DW-1:0] exp;
    int pushes = 0;
    w = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    exp = 128'h00112233445566778899AABBCCDDEEFF;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, w[i], 1'b0, 1'b0);
      #1;
      n_cmp++;
      if (bus.in_ready_o !== 1'b1 || bus.push_o !== 1'b0) begin
        n_bad++;
        $display("FAIL basic_fill%0d: rdy %b push %b want 1 0",
                 i, bus.in_ready_o, bus.push_o);
      end
      step();
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, '0, 1'b0, 1'b0);
      #1;
      if (bus.push_o === 1'b1) begin
        pushes++;
        n_cmp++;
        if (c != 0 || bus.data_o !== exp) begin
          n_bad++;
          $display("FAIL basic_push: cycle %0d data %h want cycle 0 %h",
                   c, bus.data_o, exp);
        end
      end
      step();
    end
    #1;
    n_cmp++;
    if (pushes != 1) begin
      n_bad++;
      $display("FAIL basic_npush: got %0d want 1", pushes);
    end
    n_cmp++;
    if (bus.blk_cnt_o !== 16'd1) begin
      n_bad++;
      $display("FAIL basic_cnt: got %0d want 1", bus.blk_cnt_o);
    end
  endtask

  task automatic test_backpressure();
    logic [WW-1:0] w[$];
    logic [DW-1:0] exp;
    do_reset();
    for (int i = 0; i < NW; i++) w.push_back($urandom);
    exp = pack(w);
    for (int i = 0; i < NW; i++) begin
      drive(1'b1, w[i], 1'b0, i == NW - 1);
      step();
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, $urandom, 1'b0, 1'b1);
      #1;
      n_cmp++;
      if (bus.push_o !== 1'b0 || bus.in_ready_o !== 1'b0 ||
          bus.data_o !== exp) begin
        n_bad++;
        $display("FAIL bp_hold%0d: push %b rdy %b data %h want 0 0 %h",
                 c, bus.push_o, bus.in_ready_o, bus.data_o, exp);
      end
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (bus.push_o !== 1'b1 || bus.in_ready_o !== 1'b0 ||
        bus.data_o !== exp) begin
      n_bad++;
      $display("FAIL bp_release: push %b rdy %b data %h want 1 0 %h",
               bus.push_o, bus.in_ready_o, bus.data_o, exp);
    end
    step();
    #1;
    n_cmp++;
    if (bus.push_o !== 1'b0 || bus.in_ready_o !== 1'b1 ||
        bus.blk_cnt_o !== 16'd1) begin
      n_bad++;
      $display("FAIL bp_after: push %b rdy %b cnt %0d want 0 1 1",
               bus.push_o, bus.in_ready_o, bus.blk_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] w[$];
    int wi = 0;
    int nlow = 0;
    int npush = 0;
    logic [WW-1:0] b[$];
    do_reset();
    for (int i = 0; i < 3 * NW; i++) w.push_back($urandom);
    for (int c = 0; c < 3 * (NW + 1); c++) begin
      drive(1'b1, w[wi % (3 * NW)], 1'b0, 1'b0);
      #1;
      if (bus.in_ready_o !== 1'b1) nlow++;
      if (bus.push_o === 1'b1) begin
        b.delete();
        for (int k = 0; k < NW; k++) b.push_back(w[npush * NW + k]);
        n_cmp++;
        if (bus.data_o !== pack(b)) begin
          n_bad++;
          $display("FAIL b2b_data%0d: got %h want %h",
                   npush, bus.data_o, pack(b));
        end
        npush++;
      end
      if (bus.in_ready_o === 1'b1) wi++;
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (nlow != 3 || npush != 3 || bus.blk_cnt_o !== 16'd3) begin
      n_bad++;
      $display("FAIL b2b_counts: low %0d push %0d cnt %0d want 3 3 3",
               nlow, npush, bus.blk_cnt_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [WW-1:0] w[$];
    int pushes = 0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'hBAD0_0000 + i, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    if (bus.push_o === 1'b1) pushes++;
    step();
    rst = 1'b0;
    for (int i = 0; i < NW; i++) w.push_back($urandom);
    for (int i = 0; i < NW; i++) begin
      drive(1'b1, w[i], 1'b0, 1'b0);
      #1;
      if (bus.push_o === 1'b1) pushes++;
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (pushes != 0) begin
      n_bad++;
      $display("FAIL rmid_early_push: got %0d want 0", pushes);
    end
    n_cmp++;
    if (bus.push_o !== 1'b1 || bus.data_o !== pack(w)) begin
      n_bad++;
      $display("FAIL rmid_block: push %b data %h want 1 %h",
               bus.push_o, bus.data_o, pack(w));
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.push_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rpush_push: got %b want 0", bus.push_o);
    end
    step();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (bus.push_o !== 1'b0 || bus.in_ready_o !== 1'b1 ||
        bus.blk_cnt_o !== 16'd0) begin
      n_bad++;
      $display("FAIL rpush_after: push %b rdy %b cnt %0d want 0 1 0",
               bus.push_o, bus.in_ready_o, bus.blk_cnt_o);
    end
  endtask

  task automatic test_pad();
    logic [DW-1:0] exp;
    do_reset();
    drive(1'b1, 32'hAAAAAAAA, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hBBBBBBBB, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
`ifdef PACKER_PAD_EN
    exp = 128'hAAAAAAAABBBBBBBB0000000000000000;
    n_cmp++;
    if (bus.push_o !== 1'b1 || bus.data_o !== exp) begin
      n_bad++;
      $display("FAIL pad_block: push %b data %h want 1 %h",
               bus.push_o, bus.data_o, exp);
    end
    step();
`else
    exp = 128'hAAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD;
    n_cmp++;
    if (bus.push_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL nopad_hold: push %b rdy %b want 0 1",
               bus.push_o, bus.in_ready_o);
    end
    step();
    drive(1'b1, 32'hCCCCCCCC, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hDDDDDDDD, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (bus.push_o !== 1'b1 || bus.data_o !== exp) begin
      n_bad++;
      $display("FAIL nopad_block: push %b data %h want 1 %h",
               bus.push_o, bus.data_o, exp);
    end
    step();
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.cnt = 16'hFFFF;
    #1;
    release dut.cnt;
    m_cnt = 16'hFFFF;
    for (int i = 0; i < NW; i++) begin
      drive(1'b1, $urandom, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    #1;
    n_cmp++;
    if (bus.blk_cnt_o !== 16'h0000 || m_cnt !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap_cnt: got %h want 0000", bus.blk_cnt_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 2) != 0, $urandom,
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 3);
      #1;
      n_cmp++;
      if (bus.in_ready_o !== exp_ready() || bus.push_o !== exp_push()) begin
        n_bad++;
        $display("FAIL rnd_hs@%0d: rdy %b push %b want %b %b", c,
                 bus.in_ready_o, bus.push_o, exp_ready(), exp_push());
      end
      n_cmp++;
      if (bus.blk_cnt_o !== m_cnt) begin
        n_bad++;
        $display("FAIL rnd_cnt@%0d: got %h want %h", c, bus.blk_cnt_o, m_cnt);
      end
      if (m_pend && !rst) begin
        n_cmp++;
        if (bus.data_o !== m_blk) begin
          n_bad++;
          $display("FAIL rnd_data@%0d: got %h want %h", c, bus.data_o, m_blk);
        end
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    m_pend = 1'b0;
    m_blk  = '0;
    m_cnt  = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_pad();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
